sipo_deserializer: RTL and testbench
====================================

# sipo_deserializer

Serial-in, parallel-out deserializer that assembles WIDTH serial bits, qualified by a bit strobe, into a parallel word presented with a valid/ready handshake. It is the receive end of the team's PISO serial link: a PISO transmitter's serial output feeds `serial_in`, and the word loaded into the PISO reappears on `parallel_out`. A shift stage and an output holding register allow the next word to be collected while the current one waits for the consumer.

## Interface
- `WIDTH`, 4: word width in bits; legal range 2..32.
- `MSB_FIRST`, 1: 1 means the first received bit lands in `parallel_out[WIDTH-1]`; 0 means it lands in bit 0.
- `clk`  input  1  rising-edge clock; the block's only clock.
- `reset`  input  1  asynchronous, active-low reset; asserting low clears all state immediately.
- `serial_in`  input  1  serial data bit, sampled only when `bit_valid`=1.
- `bit_valid`  input  1  strobe: the current `serial_in` is one data bit.
- `clear`  input  1  synchronous abort of the partially collected word.
- `parallel_out`  output  WIDTH  assembled word, held stable while `out_valid`=1.
- `out_valid`  output  1  `parallel_out` holds an unconsumed word.
- `out_ready`  input  1  consumer accepts the word when `out_valid` & `out_ready`.
- `overrun`  output  1  one-cycle pulse: a completed word was dropped.
- `busy`  output  1  bit count nonzero (partial word in progress).

## Operation
- Reset (`reset`=0): shift register, bit count, `parallel_out` = 0; `out_valid`, `overrun`, `busy` = 0.
- Collection: each edge with `bit_valid`=1 shifts `serial_in` in. With MSB_FIRST=1, shift left and insert at bit 0; with MSB_FIRST=0, shift right and insert at bit WIDTH-1. The bit count increments, modulo WIDTH.
- Completion: the edge accepting the WIDTH-th bit wraps the count to 0.
  - If the holding register is free, or is being consumed on the same edge, the assembled word (including that bit) is written to `parallel_out` and `out_valid` is set to 1.
  - Otherwise the new word is dropped, `parallel_out` keeps the old word, and `overrun` pulses for one cycle.
- Handshake: `out_valid` stays 1 until an edge with `out_ready`=1. `parallel_out` does not change while `out_valid`=1 except on a consume-and-reload edge. `out_ready` while `out_valid`=0 has no effect.
- Simultaneous consume and completion: the new word loads and `out_valid` stays 1 with no gap and no overrun.
- `clear`=1: the bit count and shift register go to 0. The bit on that edge is discarded even if `bit_valid`=1. The holding register and `out_valid` are unaffected. `clear` takes priority over completion.
- Gaps: cycles with `bit_valid`=0 hold all collection state; no timeout.
- State summary:
  - Collection: COUNT 0..WIDTH-1.
  - Output: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
  - EMPTY→FULL on completion; FULL→EMPTY on consume without completion; FULL→FULL on consume plus completion, or on overrun.

## Timing
- All outputs are registered.
- Latency: the word is visible on `parallel_out`/`out_valid` immediately after the edge that accepts the WIDTH-th bit. With continuous `bit_valid`, the first word appears WIDTH cycles after the first accepted bit.
- Throughput: one word per WIDTH strobed cycles, sustained when `out_ready` is held at 1.
- `overrun` is high exactly one cycle, starting after the dropped completion edge.
- `busy` = (count != 0), registered.
- Reset mid-word: all outputs drop within the same cycle, asynchronously. The first bit after reset release starts a fresh word.

## Structure
- Shared package `serial_link_pkg`: `DEFAULT_WIDTH`=4, the `MSB_FIRST` encoding constants, and the output-state enum (EMPTY/FULL) so the PISO transmitter and this block agree on bit order.
- Count width is $clog2(WIDTH).
- One sub-module is natural: `sipo_shift_reg`, holding the WIDTH-bit shift register with direction parameter, shift enable and synchronous clear. Counter, handshake and overrun logic stay in the top.

## Test plan
- WIDTH=4, MSB_FIRST=1, bits 1,0,1,0 on 4 consecutive strobes, `out_ready`=0 → `parallel_out`=4'b1010 and `out_valid`=1 right after the 4th edge; both hold until `out_ready`=1, then `out_valid`=0.
- MSB_FIRST=0, same bit stream → `parallel_out`=4'b0101; `bit_valid` gaps of 3 cycles between bits → same result, delayed only by the gaps.
- Word 1010 held unconsumed, then 1100 completes → `overrun` one-cycle pulse, `parallel_out` stays 4'b1010; after consume, 0011 completes and loads normally.
- `out_ready`=1 on the same edge that completes 0110 while 1010 is held → `parallel_out`=4'b0110, `out_valid` continuously 1, no overrun.
- Reset low after 2 bits, released, then bits 1,1,1,1 → `parallel_out`=4'b1111; `clear` after 3 bits followed by 1,0,0,1 → 4'b1001.
- Loopback: PISO loaded with 4'b1010 drives `serial_in` → `parallel_out`=4'b1010, repeated for 0000, 1111 and 0110.

Source files
------------

// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial link (PISO transmitter and SIPO receiver).
// Contents:
//   DEFAULT_WIDTH                    default word width in bits
//   MSB_FIRST_ORDER/LSB_FIRST_ORDER  encodings of the bit-order parameter
//   out_state_e                      output holding register state (EMPTY/FULL)
package serial_link_pkg;

   localparam int DEFAULT_WIDTH = 4;

   // Bit-order encoding, shared so both link ends agree on which bit travels first.
   localparam bit MSB_FIRST_ORDER = 1'b1;
   localparam bit LSB_FIRST_ORDER = 1'b0;

   // Output holding register state.
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_e;

endpackage : serial_link_pkg

// File: rtl/sipo_deserializer_if.sv
// Bundle of the deserializer's data-path and handshake signals.
// Signals:
//   serial_in, bit_valid, clear  serial side, driven by the link/controller
//   out_ready                    consumer accepts the held word
//   parallel_out, out_valid      assembled word and its valid flag
//   overrun, busy                status from the deserializer
// Modports:
//   master  the environment driving serial data and consuming words
//   slave   the deserializer itself
interface sipo_deserializer_if
   import serial_link_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) ();

   logic             serial_in;
   logic             bit_valid;
   logic             clear;
   logic [WIDTH-1:0] parallel_out;
   logic             out_valid;
   logic             out_ready;
   logic             overrun;
   logic             busy;

   modport master (
      output serial_in, bit_valid, clear, out_ready,
      input  parallel_out, out_valid, overrun, busy
   );

   modport slave (
      input  serial_in, bit_valid, clear, out_ready,
      output parallel_out, out_valid, overrun, busy
   );

endinterface : sipo_deserializer_if

// File: rtl/sipo_shift_reg.sv
// WIDTH-bit serial-in shift register with selectable direction.
// Ports:
//   clk, reset  clock and asynchronous active-low reset
//   clr         synchronous clear to zero (wins over shift_en)
//   shift_en    shift bit_in into the register this edge
//   bit_in      serial data bit
//   q           current register contents
//   next_q      value q takes if shifted this edge (includes bit_in)
module sipo_shift_reg
   import serial_link_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit MSB_FIRST = MSB_FIRST_ORDER
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             bit_in,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] next_q
);

   logic [WIDTH-1:0] q_r;

   // Shifted value: MSB-first shifts left so the first bit ends at the top.
   always_comb begin
      next_q = q_r;
      if (MSB_FIRST) begin
         next_q = {q_r[WIDTH-2:0], bit_in};
      end else begin
         next_q = {bit_in, q_r[WIDTH-1:1]};
      end
   end

   // Shift register state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_r <= {WIDTH{1'b0}};
      end else if (clr) begin
         q_r <= {WIDTH{1'b0}};
      end else if (shift_en) begin
         q_r <= next_q;
      end else begin
         q_r <= q_r;
      end
   end

   assign q = q_r;

endmodule : sipo_shift_reg

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer with a valid/ready output holding register.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    sipo_deserializer_if.slave: serial_in/bit_valid/clear in,
//          parallel_out/out_valid/out_ready handshake, overrun/busy status
// The shift stage collects the next word while the holding register waits
// for the consumer; a completion with the holding register still full and
// not being consumed drops the new word and pulses overrun.
module sipo_deserializer
   import serial_link_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit MSB_FIRST = MSB_FIRST_ORDER
) (
   input logic                clk,
   input logic                reset,
   sipo_deserializer_if.slave bus
);

   localparam int             CW         = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST_COUNT = CW'(WIDTH - 1);

   logic [CW-1:0]    count_r;
   logic [CW-1:0]    count_next_s;
   logic [WIDTH-1:0] word_r;
   logic [WIDTH-1:0] shift_q_s;
   logic [WIDTH-1:0] shift_next_s;
   out_state_e       state_r;
   logic             overrun_r;
   logic             busy_r;
   logic             shift_en_s;
   logic             complete_s;

   // clear discards the bit on its edge, so it also blocks the shift and completion.
   assign shift_en_s = bus.bit_valid & ~bus.clear;
   assign complete_s = shift_en_s & (count_r == LAST_COUNT);

   sipo_shift_reg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shift (
      .clk      (clk),
      .reset    (reset),
      .clr      (bus.clear),
      .shift_en (shift_en_s),
      .bit_in   (bus.serial_in),
      .q        (shift_q_s),
      .next_q   (shift_next_s)
   );

   // Next bit count; wraps explicitly so non-power-of-two widths work.
   always_comb begin
      count_next_s = count_r;
      if (bus.clear) begin
         count_next_s = {CW{1'b0}};
      end else if (bus.bit_valid) begin
         if (count_r == LAST_COUNT) begin
            count_next_s = {CW{1'b0}};
         end else begin
            count_next_s = count_r + CW'(1'b1);
         end
      end else begin
         count_next_s = count_r;
      end
   end

   // Counter, output FSM, holding register and status flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_r   <= {CW{1'b0}};
         word_r    <= {WIDTH{1'b0}};
         state_r   <= EMPTY;
         overrun_r <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         count_r   <= count_next_s;
         // busy follows the count register it describes, hence the next value.
         busy_r    <= (count_next_s != {CW{1'b0}});
         overrun_r <= 1'b0;
         case (state_r)
            EMPTY: begin
               if (complete_s) begin
                  word_r  <= shift_next_s;
                  state_r <= FULL;
               end else begin
                  state_r <= EMPTY;
               end
            end
            FULL: begin
               if (complete_s) begin
                  if (bus.out_ready) begin
                     // Consume and reload on the same edge: no bubble.
                     word_r  <= shift_next_s;
                     state_r <= FULL;
                  end else begin
                     overrun_r <= 1'b1;
                     state_r   <= FULL;
                  end
               end else if (bus.out_ready) begin
                  state_r <= EMPTY;
               end else begin
                  state_r <= FULL;
               end
            end
            default: begin
               state_r <= EMPTY;
            end
         endcase
      end
   end

   assign bus.parallel_out = word_r;
   assign bus.out_valid    = (state_r == FULL);
   assign bus.overrun      = overrun_r;
   assign bus.busy         = busy_r;

   // The partial word itself is only observable through busy.
   logic unused_s;
   assign unused_s = ^shift_q_s;

endmodule : sipo_deserializer

// File: tb/tb_sipo_deserializer.sv
// Directed bench: an MSB-first and an LSB-first instance share one stimulus
// stream; the LSB-first instance must always show the bit-reversed word.
module tb_sipo_deserializer;
   import serial_link_pkg::*;

   localparam int W = 4;

   logic clk = 1'b0;
   logic reset;
   logic ser, bv, clr, rdy;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   sipo_deserializer_if #(.WIDTH(W)) bus_m ();
   sipo_deserializer_if #(.WIDTH(W)) bus_l ();

   assign bus_m.serial_in = ser;
   assign bus_m.bit_valid = bv;
   assign bus_m.clear     = clr;
   assign bus_m.out_ready = rdy;
   assign bus_l.serial_in = ser;
   assign bus_l.bit_valid = bv;
   assign bus_l.clear     = clr;
   assign bus_l.out_ready = rdy;

   sipo_deserializer #(.WIDTH(W), .MSB_FIRST(MSB_FIRST_ORDER)) dut_m (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_m)
   );

   sipo_deserializer #(.WIDTH(W), .MSB_FIRST(LSB_FIRST_ORDER)) dut_l (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_l)
   );

   function automatic logic [W-1:0] rev(input logic [W-1:0] w);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = w[W-1-i];
      return r;
   endfunction

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk_vec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // stream is written first-bit-leftmost; the LSB-first instance reverses it.
   task automatic chk_word(input string tag, input logic [W-1:0] stream);
      chk_vec({tag, "_word_m"}, bus_m.parallel_out, stream);
      chk_vec({tag, "_word_l"}, bus_l.parallel_out, rev(stream));
      chk_bit({tag, "_valid_m"}, bus_m.out_valid, 1'b1);
      chk_bit({tag, "_valid_l"}, bus_l.out_valid, 1'b1);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic b);
      ser = b;
      bv  = 1'b1;
      step();
      bv  = 1'b0;
      ser = 1'b0;
   endtask

   // Model of the PISO transmitter: shifts the loaded word out MSB first.
   task automatic piso_send(input logic [W-1:0] w);
      logic [W-1:0] sh;
      sh = w;
      for (int i = 0; i < W; i++) begin
         send(sh[W-1]);
         sh = {sh[W-2:0], 1'b0};
      end
   endtask

   task automatic consume(input string tag);
      rdy = 1'b1;
      step();
      rdy = 1'b0;
      chk_bit({tag, "_consumed_m"}, bus_m.out_valid, 1'b0);
      chk_bit({tag, "_consumed_l"}, bus_l.out_valid, 1'b0);
   endtask

   logic [W-1:0] s;
   logic [W-1:0] lb [4];

   initial begin
      reset = 1'b0;
      ser = 1'b0; bv = 1'b0; clr = 1'b0; rdy = 1'b0;
      step();
      step();
      chk_vec("rst_word_m", bus_m.parallel_out, 4'b0000);
      chk_vec("rst_word_l", bus_l.parallel_out, 4'b0000);
      chk_bit("rst_valid", bus_m.out_valid, 1'b0);
      chk_bit("rst_overrun", bus_m.overrun, 1'b0);
      chk_bit("rst_busy", bus_m.busy, 1'b0);
      reset = 1'b1;
      step();

      // Basic word, held until consumed.
      send(1'b1);
      chk_bit("t1_busy_after_first", bus_m.busy, 1'b1);
      send(1'b0);
      send(1'b1);
      chk_bit("t1_not_valid_yet", bus_m.out_valid, 1'b0);
      send(1'b0);
      chk_word("t1", 4'b1010);
      chk_bit("t1_busy_idle", bus_m.busy, 1'b0);
      step(); step(); step();
      chk_word("t1_hold", 4'b1010);
      consume("t1");

      // Gaps of 3 idle cycles between strobes.
      s = 4'b1010;
      for (int i = W - 1; i >= 1; i--) begin
         send(s[i]);
         repeat (3) step();
      end
      chk_bit("t2_gap_not_valid", bus_m.out_valid, 1'b0);
      chk_bit("t2_gap_busy", bus_m.busy, 1'b1);
      send(s[0]);
      chk_word("t2", 4'b1010);
      consume("t2");

      // Overrun: second word completes while the first is still held.
      piso_send(4'b1010);
      chk_word("t3_first", 4'b1010);
      piso_send(4'b1100);
      chk_bit("t3_overrun_m", bus_m.overrun, 1'b1);
      chk_bit("t3_overrun_l", bus_l.overrun, 1'b1);
      chk_word("t3_kept", 4'b1010);
      step();
      chk_bit("t3_overrun_pulse_end", bus_m.overrun, 1'b0);
      chk_word("t3_kept_later", 4'b1010);
      consume("t3");
      piso_send(4'b0011);
      chk_word("t3_next", 4'b0011);
      chk_bit("t3_next_no_overrun", bus_m.overrun, 1'b0);
      consume("t3_next");

      // Consume on the same edge that completes the next word.
      piso_send(4'b1010);
      send(1'b0);
      send(1'b1);
      send(1'b1);
      chk_word("t4_held", 4'b1010);
      rdy = 1'b1;
      send(1'b0);
      rdy = 1'b0;
      chk_word("t4_reload", 4'b0110);
      chk_bit("t4_no_overrun", bus_m.overrun, 1'b0);
      consume("t4");

      // Asynchronous reset in the middle of a word with a word held.
      piso_send(4'b1010);
      send(1'b1);
      send(1'b1);
      chk_bit("t5_busy_mid", bus_m.busy, 1'b1);
      reset = 1'b0;
      #1;
      chk_bit("t5_async_valid", bus_m.out_valid, 1'b0);
      chk_vec("t5_async_word", bus_m.parallel_out, 4'b0000);
      chk_bit("t5_async_busy", bus_m.busy, 1'b0);
      step();
      reset = 1'b1;
      step();
      piso_send(4'b1111);
      chk_word("t5", 4'b1111);
      consume("t5");

      // Clear on the would-be completion edge, then a fresh word.
      send(1'b1);
      send(1'b0);
      send(1'b1);
      clr = 1'b1;
      send(1'b1);
      clr = 1'b0;
      chk_bit("t6_clear_busy", bus_m.busy, 1'b0);
      chk_bit("t6_clear_no_valid", bus_m.out_valid, 1'b0);
      piso_send(4'b1001);
      chk_word("t6", 4'b1001);
      consume("t6");

      // Loopback from the PISO model.
      lb[0] = 4'b1010;
      lb[1] = 4'b0000;
      lb[2] = 4'b1111;
      lb[3] = 4'b0110;
      for (int k = 0; k < 4; k++) begin
         piso_send(lb[k]);
         chk_word("t7_loop", lb[k]);
         consume("t7_loop");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_sipo_deserializer
